// File: rtl/cla_pkg.sv
// Shared constants and FSM state type for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 32;
    localparam int unsigned CLA_GROUP = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_state_e;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: per-bit sums, carry-out and group propagate/generate.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             p_grp,
    output logic             g_grp
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             gen;
    logic             prop;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum-of-products of generates and propagates, not a ripple chain.
    always_comb begin
        c    = '0;
        c[0] = c_in;
        gen  = 1'b0;
        prop = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            gen  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen  = gen | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = gen | (prop & c_in);
        end
        s     = p ^ c[GROUP-1:0];
        c_out = c[GROUP];
        p_grp = prop;
        g_grp = gen;
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor resolving one GROUP-bit lookahead slice per cycle, LSB slice first.
// Optional signed-overflow output enabled by defining CLA_SEQ_ADDER_OVF_EN.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SEQ_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned CW = (NG > 1) ? $clog2(NG) : 1;

    if ((WIDTH % GROUP) != 0 || GROUP == 0) begin : g_width_check
        $error("cla_seq_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    cla_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
`ifdef CLA_SEQ_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [GROUP-1:0] grp_s;
    logic             grp_cout;
    logic             grp_p;
    logic             grp_g;
    logic             carry_next;
    logic [WIDTH-1:0] res_shift;

    // Operand registers shift right each step, so the active slice is always the low GROUP bits.
    cla_group #(
        .GROUP (GROUP)
    ) u_group (
        .a     (a_q[GROUP-1:0]),
        .b     (b_q[GROUP-1:0]),
        .c_in  (c_q),
        .s     (grp_s),
        .c_out (grp_cout),
        .p_grp (grp_p),
        .g_grp (grp_g)
    );

    assign carry_next = grp_g | (grp_p & c_q);
    assign res_shift  = (res_q >> GROUP) | (WIDTH'(grp_s) << (WIDTH - GROUP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
`ifdef CLA_SEQ_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub | cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> GROUP;
                b_d   = b_q >> GROUP;
                c_d   = carry_next;
                res_d = res_shift;
                if (cnt_q == CW'(NG - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = grp_cout;
                    zero_d  = (res_shift == '0);
`ifdef CLA_SEQ_ADDER_OVF_EN
                    // Carry into the MSB recovered from its sum bit and effective operands.
                    ovf_d   = (grp_s[GROUP-1] ^ a_q[GROUP-1] ^ b_q[GROUP-1]) ^ grp_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef CLA_SEQ_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
`ifdef CLA_SEQ_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
`ifdef CLA_SEQ_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder at WIDTH=8, GROUP=4; ovf checks need CLA_SEQ_ADDER_OVF_EN.
module tb_cla_seq_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       zero;
`ifdef CLA_SEQ_ADDER_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    cla_seq_adder #(
        .WIDTH (8),
        .GROUP (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CLA_SEQ_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one operand set, return edges from accept to out_valid (99 = timed out).
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          input logic tc, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("idle_after_consume", {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic ts, input logic tc, input logic [7:0] es,
                      input logic ec, input logic ez);
        int lat;
        launch(ta, tb_v, ts, tc, lat);
        check({tag, "_latency"}, lat, 32'd2);
        check({tag, "_sum"}, {24'b0, sum}, {24'b0, es});
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
        consume();
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_sum", {24'b0, sum}, 32'd0);
        check("reset_cout_zero", {30'b0, cout, zero}, 32'd0);
`ifdef CLA_SEQ_ADDER_OVF_EN
        check("reset_ovf", {31'b0, ovf}, 32'd0);
`endif

        op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        op("add_cin", 8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        op("sub_ignores_cin", 8'h09, 8'h09, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);

        launch(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        check("add_7f_01_sum", {24'b0, sum}, 32'h80);
        check("add_7f_01_cout", {31'b0, cout}, 32'd0);
`ifdef CLA_SEQ_ADDER_OVF_EN
        check("add_7f_01_ovf", {31'b0, ovf}, 32'd1);
`endif
        consume();
        launch(8'h80, 8'h80, 1'b0, 1'b0, lat);
        check("add_80_80_sum", {24'b0, sum}, 32'h00);
        check("add_80_80_cout", {31'b0, cout}, 32'd1);
`ifdef CLA_SEQ_ADDER_OVF_EN
        check("add_80_80_ovf", {31'b0, ovf}, 32'd1);
`endif
        consume();

        // Backpressure: result must hold while new operands are offered and refused.
        launch(8'h12, 8'h34, 1'b0, 1'b0, lat);
        check("bp_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0]; a = 8'hAA; b = 8'h55;
            check("bp_sum", {24'b0, sum}, 32'h46);
            check("bp_flags", {28'b0, out_valid, in_ready, cout, zero}, 32'b1000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        repeat (2) @(posedge clk);
        #1 check("bp_no_stray_op", {31'b0, out_valid}, 32'd0);

        // Reset one cycle into RUN abandons the operation.
        @(negedge clk);
        a = 8'h55; b = 8'h11; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_run_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_run_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_run_sum", {24'b0, sum}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("rst_run_no_result", {31'b0, out_valid}, 32'd0);
        op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
